operand_fetch: RTL

Register-read stage between instruction decode and execute. Drives the `registers` read ports and captures both operands. Resolves read-after-write hazards against the EX and WB stages by bypassing or stalling, then holds the result in a one-entry ID/EX pipeline register with a valid/ready handshake.

---
 rtl/operand_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with RAW hazard resolution feeding a one-entry ID/EX register.
// Define OPERAND_FETCH_FWD_EN for EX/WB bypassing (load-use stalls only); otherwise every RAW hazard stalls.
module operand_fetch #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_op,
    input  logic [AW-1:0]  in_rs1,
    input  logic [AW-1:0]  in_rs2,
    input  logic           in_use_rs1,
    input  logic           in_use_rs2,
    input  logic [AW-1:0]  in_ws,
    input  logic           in_wen,
    input  logic           in_is_load,
    input  logic [DW-1:0]  in_imm,
    output logic [AW-1:0]  rf_rs1,
    output logic [AW-1:0]  rf_rs2,
    output logic           rf_rf,
    input  logic [DW-1:0]  rf_rd1,
    input  logic [DW-1:0]  rf_rd2,
    input  logic           ex_valid,
    input  logic           ex_wen,
    input  logic           ex_is_load,
    input  logic [AW-1:0]  ex_ws,
    input  logic [DW-1:0]  ex_result,
    input  logic           wb_valid,
    input  logic           wb_wf,
    input  logic [AW-1:0]  wb_ws,
    input  logic [DW-1:0]  wb_wd,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_op,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [DW-1:0]  out_imm,
    output logic [AW-1:0]  out_ws,
    output logic           out_wen,
    output logic           out_is_load
);

    logic           exHit1, exHit2, wbHit1, wbHit2;
    logic           hazard, loadEn, accept;
    logic [DW-1:0]  opA, opB;

    logic           outValid_q, outValid_d;
    logic [OPW-1:0] outOp_q, outOp_d;
    logic [DW-1:0]  outA_q, outA_d;
    logic [DW-1:0]  outB_q, outB_d;
    logic [DW-1:0]  outImm_q, outImm_d;
    logic [AW-1:0]  outWs_q, outWs_d;
    logic           outWen_q, outWen_d;
    logic           outIsLoad_q, outIsLoad_d;

    // WB write enable is active-low, matching the register file port.
    assign exHit1 = in_use_rs1 & ex_valid & ex_wen & (ex_ws == in_rs1);
    assign exHit2 = in_use_rs2 & ex_valid & ex_wen & (ex_ws == in_rs2);
    assign wbHit1 = in_use_rs1 & wb_valid & ~wb_wf & (wb_ws == in_rs1);
    assign wbHit2 = in_use_rs2 & wb_valid & ~wb_wf & (wb_ws == in_rs2);

`ifdef OPERAND_FETCH_FWD_EN
    assign hazard = in_valid & ex_is_load & (exHit1 | exHit2);
    assign opA    = (exHit1 & ~ex_is_load) ? ex_result : (wbHit1 ? wb_wd : rf_rd1);
    assign opB    = (exHit2 & ~ex_is_load) ? ex_result : (wbHit2 ? wb_wd : rf_rd2);
`else
    assign hazard = in_valid & (exHit1 | exHit2 | wbHit1 | wbHit2);
    assign opA    = rf_rd1;
    assign opB    = rf_rd2;

    logic unusedFwd;
    assign unusedFwd = ^{ex_result, ex_is_load, wb_wd};
`endif

    assign loadEn   = out_ready | ~outValid_q;
    assign in_ready = loadEn & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;
    assign rf_rf  = in_valid;

    // Operands are sampled only when an instruction loads; a held entry keeps its values.
    always_comb begin
        outValid_d  = outValid_q;
        outOp_d     = outOp_q;
        outA_d      = outA_q;
        outB_d      = outB_q;
        outImm_d    = outImm_q;
        outWs_d     = outWs_q;
        outWen_d    = outWen_q;
        outIsLoad_d = outIsLoad_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (accept) begin
            outValid_d  = 1'b1;
            outOp_d     = in_op;
            outA_d      = opA;
            outB_d      = opB;
            outImm_d    = in_imm;
            outWs_d     = in_ws;
            outWen_d    = in_wen;
            outIsLoad_d = in_is_load;
        end else if (loadEn) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outOp_q     <= '0;
            outA_q      <= '0;
            outB_q      <= '0;
            outImm_q    <= '0;
            outWs_q     <= '0;
            outWen_q    <= 1'b0;
            outIsLoad_q <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            outOp_q     <= outOp_d;
            outA_q      <= outA_d;
            outB_q      <= outB_d;
            outImm_q    <= outImm_d;
            outWs_q     <= outWs_d;
            outWen_q    <= outWen_d;
            outIsLoad_q <= outIsLoad_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_op      = outOp_q;
    assign out_a       = outA_q;
    assign out_b       = outB_q;
    assign out_imm     = outImm_q;
    assign out_ws      = outWs_q;
    assign out_wen     = outWen_q;
    assign out_is_load = outIsLoad_q;

endmodule
